// File: rtl/onewire_pkg.sv
// onewire_pkg
// Shared definitions for the 1-Wire master and slave-side blocks:
//   - command op encodings (op_e)
//   - link-layer FSM states (state_e)
//   - default timing constants, in microseconds
//   - phase_width(): width of a saturating phase counter that can hold
//     the longest reset phase
package onewire_pkg;

  localparam int OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_RESET = 2'b00,
    OP_WRITE = 2'b01,
    OP_READ  = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RST_LOW,
    ST_RST_REL,
    ST_SLOT_LOW,
    ST_SLOT_REL,
    ST_DONE
  } state_e;

  localparam int DEF_CLKS_PER_US    = 1;
  localparam int DEF_RST_LOW_US     = 480;
  localparam int DEF_PRES_SAMPLE_US = 70;
  localparam int DEF_RST_REL_US     = 480;
  localparam int DEF_SLOT_US        = 70;
  localparam int DEF_W1_LOW_US      = 6;
  localparam int DEF_W0_LOW_US      = 60;
  localparam int DEF_RD_SAMPLE_US   = 15;

  function automatic int phase_width(input int a, input int b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/onewire_master_link_if.sv
// onewire_master_link_if
// Command/response handshake plus the open-drain bus pins of the 1-Wire
// master link layer.
//   master modport : the link layer itself (accepts commands, drives the bus)
//   slave modport  : the byte-level controller / bus environment side
// Signals: cmd_valid, cmd_ready, cmd_op[1:0], cmd_bit, bus (sensed level),
//          master_pull_low, rsp_valid, rsp_bit, rsp_presence, rsp_fault.
interface onewire_master_link_if;
  import onewire_pkg::*;

  logic            cmd_valid;
  logic            cmd_ready;
  logic [OP_W-1:0] cmd_op;
  logic            cmd_bit;
  logic            bus;
  logic            master_pull_low;
  logic            rsp_valid;
  logic            rsp_bit;
  logic            rsp_presence;
  logic            rsp_fault;

  modport master (
    input  cmd_valid, cmd_op, cmd_bit, bus,
    output cmd_ready, master_pull_low, rsp_valid, rsp_bit, rsp_presence, rsp_fault
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_bit, bus,
    input  cmd_ready, master_pull_low, rsp_valid, rsp_bit, rsp_presence, rsp_fault
  );

endinterface

// File: rtl/onewire_us_tick.sv
// onewire_us_tick
// Microsecond prescaler. us_tick is high for one clk cycle out of every
// CLKS_PER_US; clr restarts the count so the first tick after a clear
// arrives exactly CLKS_PER_US cycles later.
// Ports: clk, rst (sync, active high), clr (sync restart), us_tick (out).
module onewire_us_tick #(
  parameter int CLKS_PER_US = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic us_tick
);

  localparam int CW = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;

  logic [CW-1:0] cnt_reg;

  // With CLKS_PER_US == 1 the count sits at zero and the tick is constant.
  assign us_tick = (cnt_reg == CW'(CLKS_PER_US - 1));

  always_ff @(posedge clk) begin
    if (rst || clr || us_tick) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/onewire_master_link.sv
// onewire_master_link
// 1-Wire bus master link layer: runs one reset/presence, write-bit or
// read-bit time slot per accepted command and returns a one-cycle response.
// Ports: clk, rst (sync, active high), link (onewire_master_link_if.master):
//   cmd_valid/cmd_ready/cmd_op/cmd_bit  command handshake
//   bus / master_pull_low               sensed level / open-drain drive
//   rsp_valid/rsp_bit/rsp_presence/rsp_fault  response (valid is a pulse)
module onewire_master_link
  import onewire_pkg::*;
#(
  parameter int CLKS_PER_US    = DEF_CLKS_PER_US,
  parameter int RST_LOW_US     = DEF_RST_LOW_US,
  parameter int PRES_SAMPLE_US = DEF_PRES_SAMPLE_US,
  parameter int RST_REL_US     = DEF_RST_REL_US,
  parameter int SLOT_US        = DEF_SLOT_US,
  parameter int W1_LOW_US      = DEF_W1_LOW_US,
  parameter int W0_LOW_US      = DEF_W0_LOW_US,
  parameter int RD_SAMPLE_US   = DEF_RD_SAMPLE_US
) (
  input logic                   clk,
  input logic                   rst,
  onewire_master_link_if.master link
);

  localparam int PW = phase_width(RST_LOW_US, RST_REL_US);

  state_e        state_reg, state_next;
  op_e           op_reg;
  logic          bit_reg;
  logic [PW-1:0] phase_reg;
  logic          bus_meta_reg, bus_s_reg;
  logic          ready_reg, pull_low_reg, rsp_valid_reg;
  logic          rsp_bit_reg, rsp_presence_reg, rsp_fault_reg;
  logic          us_tick, accept;
  logic [PW-1:0] slot_low_last;

  assign accept = link.cmd_valid && ready_reg;

  onewire_us_tick #(.CLKS_PER_US(CLKS_PER_US)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .clr     (accept),
    .us_tick (us_tick)
  );

  // Only WRITE-0 holds the bus low for the long time; READ uses the short low.
  assign slot_low_last = (op_reg == OP_WRITE && !bit_reg) ? PW'(W0_LOW_US - 1)
                                                          : PW'(W1_LOW_US - 1);

  // The bus is asynchronous to clk; everything samples bus_s_reg.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_meta_reg <= 1'b1;
      bus_s_reg    <= 1'b1;
    end else begin
      bus_meta_reg <= link.bus;
      bus_s_reg    <= bus_meta_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  // phase_reg holds the number of us already elapsed in the current phase,
  // so "phase_reg == N-1 on a tick" marks the end of an N us interval.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          case (op_e'(link.cmd_op))
            OP_RESET:         state_next = ST_RST_LOW;
            OP_WRITE, OP_READ: state_next = ST_SLOT_LOW;
            default:          state_next = ST_DONE;
          endcase
        end
      end
      ST_RST_LOW:  if (us_tick && phase_reg == PW'(RST_LOW_US - 1)) state_next = ST_RST_REL;
      ST_RST_REL:  if (us_tick && phase_reg == PW'(RST_REL_US - 1)) state_next = ST_DONE;
      ST_SLOT_LOW: if (us_tick && phase_reg == slot_low_last)       state_next = ST_SLOT_REL;
      ST_SLOT_REL: if (us_tick && phase_reg == PW'(SLOT_US - 1))    state_next = ST_DONE;
      ST_DONE:     state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  // Reset phases are timed separately; a bit slot is timed from slot start,
  // so the counter keeps running across SLOT_LOW -> SLOT_REL.
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      phase_reg <= '0;
    end else if (state_reg == ST_RST_LOW && state_next == ST_RST_REL) begin
      phase_reg <= '0;
    end else if (us_tick && phase_reg != {PW{1'b1}}) begin
      phase_reg <= phase_reg + 1'b1;
    end
  end

  // Outputs are registered from state_next so the bus drive is glitch free
  // and changes on the same edge as the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_reg           <= OP_RESET;
      bit_reg          <= 1'b0;
      ready_reg        <= 1'b1;
      pull_low_reg     <= 1'b0;
      rsp_valid_reg    <= 1'b0;
      rsp_bit_reg      <= 1'b0;
      rsp_presence_reg <= 1'b0;
      rsp_fault_reg    <= 1'b0;
    end else begin
      ready_reg     <= (state_next == ST_IDLE);
      pull_low_reg  <= (state_next == ST_RST_LOW) || (state_next == ST_SLOT_LOW);
      rsp_valid_reg <= (state_next == ST_DONE);
      if (accept) begin
        op_reg           <= op_e'(link.cmd_op);
        bit_reg          <= link.cmd_bit;
        rsp_bit_reg      <= 1'b0;
        rsp_presence_reg <= 1'b0;
        rsp_fault_reg    <= (op_e'(link.cmd_op) == OP_RSVD);
      end else begin
        if (state_reg == ST_RST_REL && us_tick) begin
          if (phase_reg == PW'(PRES_SAMPLE_US - 1)) rsp_presence_reg <= ~bus_s_reg;
          if (phase_reg == PW'(RST_REL_US - 1))     rsp_fault_reg    <= ~bus_s_reg;
        end
        if ((state_reg == ST_SLOT_LOW || state_reg == ST_SLOT_REL) && op_reg == OP_READ &&
            us_tick && phase_reg == PW'(RD_SAMPLE_US - 1)) begin
          rsp_bit_reg <= bus_s_reg;
        end
      end
    end
  end

  assign link.cmd_ready       = ready_reg;
  assign link.master_pull_low = pull_low_reg;
  assign link.rsp_valid       = rsp_valid_reg;
  assign link.rsp_bit         = rsp_bit_reg;
  assign link.rsp_presence    = rsp_presence_reg;
  assign link.rsp_fault       = rsp_fault_reg;

endmodule

// File: tb/tb_onewire_master_link.sv
// tb_onewire_master_link
// Table of commands with expected responses, a scoreboard queue of expected
// results (latency, pull-low width, response bits), a simple bus slave model
// and hand-written sequences for reset abort and back-to-back commands.
module tb_onewire_master_link;

  localparam int M_NONE  = 0;  // bus idles high
  localparam int M_PRES  = 1;  // presence pulse 15..75 us after a long reset low
  localparam int M_RD0   = 2;  // holds bus low 0..30 us after slot start
  localparam int M_STUCK = 3;  // bus shorted low

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   mode = M_NONE;
  int   checks = 0;
  int   failures = 0;
  int   rsp_count = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  onewire_master_link_if ow ();

  onewire_master_link dut (
    .clk  (clk),
    .rst  (rst),
    .link (ow)
  );

  // Slave model: counts cycles relative to the master's drive.
  logic pl_d = 1'b0;
  logic armed = 1'b0;
  int   low_run = 0;
  int   rel_cnt = 1000;
  int   slot_cnt = 1000;
  logic slave_low;

  always @(posedge clk) begin
    pl_d <= ow.master_pull_low;
    if (ow.master_pull_low) begin
      low_run <= low_run + 1;
      rel_cnt <= 0;
      armed   <= (low_run + 1 >= 400);
    end else begin
      low_run <= 0;
      rel_cnt <= rel_cnt + 1;
    end
    if (ow.master_pull_low && !pl_d) slot_cnt <= 0;
    else                             slot_cnt <= slot_cnt + 1;
  end

  assign slave_low = (mode == M_STUCK) ||
                     (mode == M_PRES && armed && rel_cnt >= 15 && rel_cnt < 75) ||
                     (mode == M_RD0 && slot_cnt < 30);
  assign ow.bus = ~(ow.master_pull_low | slave_low);

  typedef struct {
    logic e_bit;
    logic e_pres;
    logic e_fault;
    int   e_lat;
    int   e_low;
    int   acc;
    string name;
  } exp_t;

  exp_t sb_q[$];

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp_v);
    end
  endtask

  // Response monitor / scoreboard, sampled on the falling edge.
  initial begin
    int   low_cnt;
    exp_t e;
    low_cnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        low_cnt = 0;
      end else begin
        if (ow.master_pull_low) low_cnt++;
        if (ow.rsp_valid) begin
          rsp_count++;
          if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_rsp actual=rsp_valid expected=none cyc=%0d", cyc);
          end else begin
            e = sb_q.pop_front();
            $display("rsp %s: lat=%0d low=%0d bit=%0b pres=%0b fault=%0b", e.name,
                     cyc - e.acc + 1, low_cnt, ow.rsp_bit, ow.rsp_presence, ow.rsp_fault);
            chk({e.name, "_latency"},  cyc - e.acc + 1,        e.e_lat);
            chk({e.name, "_lowwidth"}, low_cnt,                e.e_low);
            chk({e.name, "_bit"},      int'(ow.rsp_bit),       int'(e.e_bit));
            chk({e.name, "_presence"}, int'(ow.rsp_presence),  int'(e.e_pres));
            chk({e.name, "_fault"},    int'(ow.rsp_fault),     int'(e.e_fault));
          end
          low_cnt = 0;
        end
      end
    end
  end

  task automatic push_exp(input logic eb, input logic ep, input logic ef,
                          input int el, input int elow, input int acc, input string nm);
    exp_t e;
    e.e_bit = eb; e.e_pres = ep; e.e_fault = ef;
    e.e_lat = el; e.e_low = elow; e.acc = acc; e.name = nm;
    sb_q.push_back(e);
  endtask

  // Issue one command; returns at the first falling edge after the accept edge.
  task automatic issue(input logic [1:0] op, input logic b, input logic eb, input logic ep,
                       input logic ef, input int el, input int elow, input string nm);
    int n;
    @(negedge clk);
    ow.cmd_op = op; ow.cmd_bit = b; ow.cmd_valid = 1'b1;
    n = 0;
    while (!ow.cmd_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!ow.cmd_ready) begin
      chk({nm, "_accept_timeout"}, 0, 1);
      ow.cmd_valid = 1'b0;
    end else begin
      $display("cmd %s: op=%0d bit=%0b accept_edge=%0d", nm, op, b, cyc + 1);
      push_exp(eb, ep, ef, el, elow, cyc + 1, nm);
      @(negedge clk);
      // Scramble the command inputs: the link must use the latched values.
      ow.cmd_valid = 1'b0; ow.cmd_op = ~op; ow.cmd_bit = ~b;
      chk({nm, "_ready_busy"}, int'(ow.cmd_ready), 0);
    end
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      chk({nm, "_rsp_timeout"}, 0, 1);
      sb_q.delete();
    end
    repeat (5) @(negedge clk);
  endtask

  typedef struct {
    logic [1:0] op;
    logic       b;
    int         mode;
    logic       e_bit;
    logic       e_pres;
    logic       e_fault;
    int         e_lat;
    int         e_low;
    string      name;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int snap;
    vecs[0] = '{2'b00, 1'b0, M_PRES,  1'b0, 1'b1, 1'b0, 961, 480, "reset_present"};
    vecs[1] = '{2'b00, 1'b0, M_NONE,  1'b0, 1'b0, 1'b0, 961, 480, "reset_absent"};
    vecs[2] = '{2'b00, 1'b0, M_STUCK, 1'b0, 1'b1, 1'b1, 961, 480, "reset_stuck"};
    vecs[3] = '{2'b01, 1'b1, M_NONE,  1'b0, 1'b0, 1'b0, 71,  6,   "write1"};
    vecs[4] = '{2'b01, 1'b0, M_NONE,  1'b0, 1'b0, 1'b0, 71,  60,  "write0"};
    vecs[5] = '{2'b10, 1'b0, M_NONE,  1'b1, 1'b0, 1'b0, 71,  6,   "read_idle"};
    vecs[6] = '{2'b10, 1'b1, M_RD0,   1'b0, 1'b0, 1'b0, 71,  6,   "read_low"};
    vecs[7] = '{2'b11, 1'b0, M_NONE,  1'b0, 1'b0, 1'b1, 1,   0,   "reserved"};

    ow.cmd_valid = 1'b0; ow.cmd_op = 2'b00; ow.cmd_bit = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_pull_low",  int'(ow.master_pull_low), 0);
    chk("rst_rsp_valid", int'(ow.rsp_valid), 0);
    chk("rst_rsp_bit",   int'(ow.rsp_bit), 0);
    chk("rst_presence",  int'(ow.rsp_presence), 0);
    chk("rst_fault",     int'(ow.rsp_fault), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", int'(ow.cmd_ready), 1);

    for (int i = 0; i < 8; i++) begin
      mode = vecs[i].mode;
      issue(vecs[i].op, vecs[i].b, vecs[i].e_bit, vecs[i].e_pres, vecs[i].e_fault,
            vecs[i].e_lat, vecs[i].e_low, vecs[i].name);
      drain(vecs[i].name);
      mode = M_NONE;
      repeat (5) @(negedge clk);
    end

    // Back-to-back: reserved op then WRITE-1 with cmd_valid held high.
    @(negedge clk);
    ow.cmd_op = 2'b11; ow.cmd_bit = 1'b0; ow.cmd_valid = 1'b1;
    chk("b2b_ready_first", int'(ow.cmd_ready), 1);
    $display("cmd b2b_reserved: op=3 accept_edge=%0d", cyc + 1);
    push_exp(1'b0, 1'b0, 1'b1, 1, 0, cyc + 1, "b2b_reserved");
    @(negedge clk);
    chk("b2b_ready_done", int'(ow.cmd_ready), 0);
    ow.cmd_op = 2'b01; ow.cmd_bit = 1'b1;
    @(negedge clk);
    chk("b2b_ready_next", int'(ow.cmd_ready), 1);
    $display("cmd b2b_write1: op=1 accept_edge=%0d", cyc + 1);
    push_exp(1'b0, 1'b0, 1'b0, 71, 6, cyc + 1, "b2b_write1");
    @(negedge clk);
    ow.cmd_valid = 1'b0;
    drain("b2b");

    // Abort a RESET with rst at cycle 200.
    mode = M_PRES;
    issue(2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 961, 480, "abort_reset");
    repeat (199) @(negedge clk);
    chk("abort_pull_before", int'(ow.master_pull_low), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_pull_low",  int'(ow.master_pull_low), 0);
    chk("abort_ready",     int'(ow.cmd_ready), 1);
    chk("abort_rsp_valid", int'(ow.rsp_valid), 0);
    sb_q.delete();
    $display("abort_reset: rst applied at cycle 200, expectation dropped");
    @(negedge clk);
    rst = 1'b0;
    snap = rsp_count;
    repeat (1000) @(negedge clk);
    chk("abort_no_rsp", rsp_count - snap, 0);

    issue(2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 961, 480, "reset_after_abort");
    drain("reset_after_abort");
    mode = M_NONE;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
